// File: rtl/cprv_pkg.sv
// cprv_pkg: shared constants and types for the cprv pipeline memory path.
// Holds the load/store opcodes, the funct3 access-size encoding, the MEM
// stage state encoding and the misalignment predicate used when
// CPRV_MISALIGN_TRAP_EN is defined.
package cprv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_D  = 3'd3,
        F3_BU = 3'd4,
        F3_HU = 3'd5,
        F3_WU = 3'd6
    } f3_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // Access size lives in funct3[1:0]; the unsigned flag in funct3[2] does not
    // change natural alignment.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
        logic mis;
        case (funct3[1:0])
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = |off[1:0];
            2'd3:    mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/cprv_lsu_align.sv
// cprv_lsu_align: combinational lane alignment for a 64-bit, 8-lane data bus.
// Store side builds byte enables and lane-shifted write data; load side
// shifts the read doubleword down and sign/zero-extends by funct3.
// Enables are 8 bits wide, so lanes shifted past byte 7 are dropped.
module cprv_lsu_align
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            off_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    input  logic [DATA_WIDTH-1:0] ld_rdata_i,
    output logic [7:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] ld_data_o
);

    logic [5:0]            sh_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    assign sh_s      = {off_i, 3'b000};
    assign wdata_o   = st_data_i << sh_s;
    assign shifted_s = ld_rdata_i >> sh_s;

    // Store byte enables by access size, shifted to the lane offset.
    always_comb begin
        case (funct3_i)
            F3_B:    be_o = 8'h01 << off_i;
            F3_H:    be_o = 8'h03 << off_i;
            F3_W:    be_o = 8'h0F << off_i;
            F3_D:    be_o = 8'hFF;
            default: be_o = 8'h00;
        endcase
    end

    // Load data extraction with sign or zero extension.
    always_comb begin
        case (funct3_i)
            F3_B:    ld_data_o = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    ld_data_o = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    ld_data_o = {{(DATA_WIDTH-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    ld_data_o = shifted_s;
            F3_BU:   ld_data_o = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
            F3_HU:   ld_data_o = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
            F3_WU:   ld_data_o = {{(DATA_WIDTH-32){1'b0}}, shifted_s[31:0]};
            default: ld_data_o = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/cprv_mem_stage.sv
// cprv_mem_stage: pipeline MEM stage. Consumes EX bundles over valid/ready,
// runs loads/stores over a req/gnt/rvalid data-memory port and registers the
// writeback bundle toward WB. Non-memory bundles pass alu_out through.
// Optional macro CPRV_MISALIGN_TRAP_EN: misaligned accesses skip the memory
// port and return a bundle flagged on misalign_wb_o with rd_en cleared.
module cprv_mem_stage
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_mem_i,
    output logic                  ready_mem_o,
    input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
    input  logic [4:0]            rd_addr_mem_i,
    input  logic                  rd_en_mem_i,
    input  logic [6:0]            opcode_mem_i,
    input  logic [2:0]            funct3_mem_i,
    input  logic                  mem_w_en_mem_i,
    input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
    output logic                  dmem_req_o,
    input  logic                  dmem_gnt_i,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [7:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
`ifdef CPRV_MISALIGN_TRAP_EN
    output logic                  misalign_wb_o,
`endif
    output logic                  valid_wb_o,
    input  logic                  ready_wb_i,
    output logic [4:0]            rd_addr_wb_o,
    output logic                  rd_en_wb_o,
    output logic [DATA_WIDTH-1:0] rd_data_wb_o
);

    mem_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [4:0]            rd_addr_q, rd_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  is_store_q, is_store_d;
    logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    logic                  valid_wb_q, valid_wb_d;
    logic [4:0]            rd_addr_wb_q, rd_addr_wb_d;
    logic                  rd_en_wb_q, rd_en_wb_d;
    logic [DATA_WIDTH-1:0] rd_data_wb_q, rd_data_wb_d;

    logic                  out_free_s, accept_s, is_mem_s, load_out_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic [4:0]            out_rd_addr_s;
    logic                  out_rd_en_s;
    logic [7:0]            be_s;
    logic [DATA_WIDTH-1:0] wdata_s, ld_data_s;
`ifdef CPRV_MISALIGN_TRAP_EN
    logic                  mis_q, mis_d, mis_wb_q, mis_wb_d, out_mis_s;
`endif

    assign out_free_s  = ~valid_wb_q | ready_wb_i;
    assign ready_mem_o = (state_q == IDLE) & out_free_s;
    assign accept_s    = valid_mem_i & ready_mem_o;
    assign is_mem_s    = mem_w_en_mem_i | (opcode_mem_i == OPC_LOAD);

    cprv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .off_i      (addr_q[2:0]),
        .funct3_i   (funct3_q),
        .st_data_i  (st_data_q),
        .ld_rdata_i (dmem_rdata_i),
        .be_o       (be_s),
        .wdata_o    (wdata_s),
        .ld_data_o  (ld_data_s)
    );

    // Memory port is driven only from latched access state; quiet outside REQ.
    always_comb begin
        dmem_addr_o  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
        dmem_wdata_o = wdata_s;
        if (state_q == REQ) begin
            dmem_req_o = 1'b1;
            dmem_we_o  = is_store_q;
            dmem_be_o  = be_s;
        end else begin
            dmem_req_o = 1'b0;
            dmem_we_o  = 1'b0;
            dmem_be_o  = 8'h00;
        end
    end

    // Access FSM: accept, request, wait for read data, hand off to WB.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        rd_addr_d     = rd_addr_q;
        rd_en_d       = rd_en_q;
        is_store_d    = is_store_q;
        st_data_d     = st_data_q;
        hold_d        = hold_q;
        load_out_s    = 1'b0;
        out_data_s    = hold_q;
        out_rd_addr_s = rd_addr_q;
        out_rd_en_s   = rd_en_q;
`ifdef CPRV_MISALIGN_TRAP_EN
        mis_d         = mis_q;
        out_mis_s     = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (is_mem_s) begin
                        addr_d     = alu_out_mem_i[ADDR_WIDTH-1:0];
                        funct3_d   = funct3_mem_i;
                        rd_addr_d  = rd_addr_mem_i;
                        rd_en_d    = rd_en_mem_i;
                        is_store_d = mem_w_en_mem_i;
                        st_data_d  = rs2_data_mem_i;
`ifdef CPRV_MISALIGN_TRAP_EN
                        if (is_misaligned(funct3_mem_i, alu_out_mem_i[2:0])) begin
                            state_d = DONE;
                            rd_en_d = 1'b0;
                            hold_d  = {DATA_WIDTH{1'b0}};
                            mis_d   = 1'b1;
                        end else begin
                            state_d = REQ;
                            mis_d   = 1'b0;
                        end
`else
                        state_d    = REQ;
`endif
                    end else begin
                        load_out_s    = 1'b1;
                        out_data_s    = alu_out_mem_i;
                        out_rd_addr_s = rd_addr_mem_i;
                        out_rd_en_s   = rd_en_mem_i;
`ifdef CPRV_MISALIGN_TRAP_EN
                        out_mis_s     = 1'b0;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (is_store_q) begin
                        state_d = DONE;
                        rd_en_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    hold_d  = ld_data_s;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (out_free_s) begin
                    load_out_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load wins over drain, so drain+load keeps valid high.
    always_comb begin
        rd_addr_wb_d = rd_addr_wb_q;
        rd_en_wb_d   = rd_en_wb_q;
        rd_data_wb_d = rd_data_wb_q;
`ifdef CPRV_MISALIGN_TRAP_EN
        mis_wb_d     = mis_wb_q;
`endif
        if (load_out_s) begin
            valid_wb_d   = 1'b1;
            rd_addr_wb_d = out_rd_addr_s;
            rd_en_wb_d   = out_rd_en_s;
            rd_data_wb_d = out_data_s;
`ifdef CPRV_MISALIGN_TRAP_EN
            mis_wb_d     = out_mis_s;
`endif
        end else if (ready_wb_i) begin
            valid_wb_d = 1'b0;
        end else begin
            valid_wb_d = valid_wb_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            funct3_q     <= 3'd0;
            rd_addr_q    <= 5'd0;
            rd_en_q      <= 1'b0;
            is_store_q   <= 1'b0;
            st_data_q    <= {DATA_WIDTH{1'b0}};
            hold_q       <= {DATA_WIDTH{1'b0}};
            valid_wb_q   <= 1'b0;
            rd_addr_wb_q <= 5'd0;
            rd_en_wb_q   <= 1'b0;
            rd_data_wb_q <= {DATA_WIDTH{1'b0}};
`ifdef CPRV_MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
            mis_wb_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            is_store_q   <= is_store_d;
            st_data_q    <= st_data_d;
            hold_q       <= hold_d;
            valid_wb_q   <= valid_wb_d;
            rd_addr_wb_q <= rd_addr_wb_d;
            rd_en_wb_q   <= rd_en_wb_d;
            rd_data_wb_q <= rd_data_wb_d;
`ifdef CPRV_MISALIGN_TRAP_EN
            mis_q        <= mis_d;
            mis_wb_q     <= mis_wb_d;
`endif
        end
    end

    assign valid_wb_o   = valid_wb_q;
    assign rd_addr_wb_o = rd_addr_wb_q;
    assign rd_en_wb_o   = rd_en_wb_q;
    assign rd_data_wb_o = rd_data_wb_q;
`ifdef CPRV_MISALIGN_TRAP_EN
    assign misalign_wb_o = mis_wb_q;
`endif

endmodule
